// File: rtl/sqrt_arb_pkg.sv
// rtl/sqrt_arb_pkg.sv - Shared constants and response type for the sqrt request arbiter
package sqrt_arb_pkg;

  localparam int SQRT_WIDTH    = 16;
  localparam int SQRT_LATENCY  = 17;
  localparam int SQRT_OUT_FRAC = 6;
  // Wide enough for the largest supported requester count (8).
  localparam int SQRT_MAX_ID_W = 3;

  typedef struct packed {
    logic [SQRT_MAX_ID_W-1:0] id;
    logic [SQRT_WIDTH-1:0]    data;
  } sqrt_rsp_t;

endpackage

// File: rtl/sqrt_req_arbiter_if.sv
// rtl/sqrt_req_arbiter_if.sv - Request, pipeline and response signals of sqrt_req_arbiter
interface sqrt_req_arbiter_if
  import sqrt_arb_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int WIDTH = SQRT_WIDTH
);
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]       req_valid;
  logic [NREQ*WIDTH-1:0] req_data;
  logic [NREQ-1:0]       req_ready;
  logic [WIDTH-1:0]      sq_N;
  logic                  sq_in_valid;
  logic [WIDTH-1:0]      sq_sqrt;
  logic                  sq_out_valid;
  logic                  rsp_valid;
  logic [IDW-1:0]        rsp_id;
  logic [WIDTH-1:0]      rsp_data;
  logic                  rsp_ready;

  modport slave (
    input  req_valid, req_data, sq_sqrt, sq_out_valid, rsp_ready,
    output req_ready, sq_N, sq_in_valid, rsp_valid, rsp_id, rsp_data
  );

  modport master (
    output req_valid, req_data, sq_sqrt, sq_out_valid, rsp_ready,
    input  req_ready, sq_N, sq_in_valid, rsp_valid, rsp_id, rsp_data
  );

endinterface

// File: rtl/sqrt_arb_fifo.sv
// rtl/sqrt_arb_fifo.sv - Show-ahead synchronous FIFO with occupancy count and same-cycle push/pop
module sqrt_arb_fifo #(
  parameter int  W     = 8,
  parameter int  DEPTH = 4,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  logic [W-1:0]  push_data_i,
  input  logic          pop_i,
  output logic [W-1:0]  pop_data_o,
  output logic          empty_o,
  output logic          full_o,
  output logic [CW-1:0] count_o
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign count_o = count_q;

  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_comb begin
    wr_d    = wr_q;
    rd_d    = rd_q;
    count_d = count_q;
    if (do_push) wr_d = (wr_q == AW'(DEPTH - 1)) ? '0 : wr_q + AW'(1);
    if (do_pop)  rd_d = (rd_q == AW'(DEPTH - 1)) ? '0 : rd_q + AW'(1);
    if (do_push && !do_pop) count_d = count_q + CW'(1);
    if (do_pop && !do_push) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= push_data_i;
  end

  assign pop_data_o = empty_o ? '0 : mem_q[rd_q];

endmodule

// File: rtl/sqrt_req_arbiter.sv
// rtl/sqrt_req_arbiter.sv - Round-robin, credit-limited sharing of one sqrt pipeline among NREQ requesters
// Optional SQRT_ARB_STATS_EN adds saturating per-requester issue and stall counters.
module sqrt_req_arbiter
  import sqrt_arb_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int WIDTH   = SQRT_WIDTH,
  parameter int LATENCY = SQRT_LATENCY,
  parameter int DEPTH   = LATENCY + 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  sqrt_req_arbiter_if.slave      bus,
  output logic                   idle,
  output logic                   err
`ifdef SQRT_ARB_STATS_EN
  ,
  output logic [NREQ*32-1:0]     stat_issued,
  output logic [31:0]            stat_stall
`endif
);

  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW  = $clog2(DEPTH + 1);
  localparam int SW  = CW + 1;
  localparam int RW  = IDW + WIDTH;

  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [WIDTH-1:0] sq_n_q, sq_n_d;
  logic             sq_v_q, sq_v_d;
  logic             err_q, err_d;

  logic             hi_found, lo_found, req_found;
  logic [IDW-1:0]   hi_id, lo_id, grant_id;
  logic [WIDTH-1:0] sel_data;
  logic             credit_ok, xfer, rsp_pop, ret_ok;

  logic             tag_empty, tag_full, res_empty, res_full;
  logic [CW-1:0]    tag_count, res_count;
  logic [IDW-1:0]   tag_head;
  logic [RW-1:0]    res_head;

  assign rsp_pop = ~res_empty & bus.rsp_ready;
  assign ret_ok  = bus.sq_out_valid & ~tag_empty;

  // Credits cover in-flight plus buffered results; a pop this cycle frees its slot immediately.
  assign credit_ok = en & ((SW'(tag_count) + SW'(res_count) - SW'(rsp_pop)) < SW'(DEPTH));

  // Round-robin: lowest valid index at or above the pointer, else lowest valid overall.
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_id    = '0;
    lo_id    = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (bus.req_valid[i] && !hi_found && (IDW'(i) >= ptr_q)) begin
        hi_found = 1'b1;
        hi_id    = IDW'(i);
      end
      if (bus.req_valid[i] && !lo_found) begin
        lo_found = 1'b1;
        lo_id    = IDW'(i);
      end
    end
  end

  assign req_found = hi_found | lo_found;
  assign grant_id  = hi_found ? hi_id : lo_id;
  assign xfer      = req_found & credit_ok & rst_n;

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_id == IDW'(i)) sel_data = bus.req_data[i*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    ptr_d  = ptr_q;
    sq_n_d = sq_n_q;
    sq_v_d = xfer;
    err_d  = err_q | (bus.sq_out_valid & tag_empty);
    if (xfer) begin
      ptr_d  = (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + IDW'(1);
      sq_n_d = sel_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q  <= '0;
      sq_n_q <= '0;
      sq_v_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      ptr_q  <= ptr_d;
      sq_n_q <= sq_n_d;
      sq_v_q <= sq_v_d;
      err_q  <= err_d;
    end
  end

  sqrt_arb_fifo #(.W(IDW), .DEPTH(DEPTH)) u_tag_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (xfer),
    .push_data_i (grant_id),
    .pop_i       (ret_ok),
    .pop_data_o  (tag_head),
    .empty_o     (tag_empty),
    .full_o      (tag_full),
    .count_o     (tag_count)
  );

  sqrt_arb_fifo #(.W(RW), .DEPTH(DEPTH)) u_res_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (ret_ok),
    .push_data_i ({tag_head, bus.sq_sqrt}),
    .pop_i       (rsp_pop),
    .pop_data_o  (res_head),
    .empty_o     (res_empty),
    .full_o      (res_full),
    .count_o     (res_count)
  );

  assign bus.req_ready   = xfer ? (NREQ'(1) << grant_id) : '0;
  assign bus.sq_N        = sq_n_q;
  assign bus.sq_in_valid = sq_v_q;
  assign bus.rsp_valid   = ~res_empty;
  assign bus.rsp_id      = res_head[RW-1 -: IDW];
  assign bus.rsp_data    = res_head[WIDTH-1:0];

  assign idle = tag_empty & res_empty & ~sq_v_q;
  assign err  = err_q;

`ifdef SQRT_ARB_STATS_EN
  logic [31:0] issued_q [NREQ];
  logic [31:0] stall_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREQ; i++) issued_q[i] <= '0;
      stall_q <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (xfer && (grant_id == IDW'(i)) && (issued_q[i] != '1)) issued_q[i] <= issued_q[i] + 32'd1;
      end
      if ((|bus.req_valid) && !xfer && (stall_q != '1)) stall_q <= stall_q + 32'd1;
    end
  end

  always_comb begin
    stat_issued = '0;
    for (int i = 0; i < NREQ; i++) stat_issued[i*32 +: 32] = issued_q[i];
  end

  assign stat_stall = stall_q;
`endif

endmodule

// File: tb/tb_sqrt_req_arbiter.sv
// tb/tb_sqrt_req_arbiter.sv - Directed and randomized bench for sqrt_req_arbiter with a sqrt pipeline model
module tb_sqrt_req_arbiter;
  import sqrt_arb_pkg::*;

  localparam int NREQ  = 4;
  localparam int WIDTH = SQRT_WIDTH;
  localparam int L     = SQRT_LATENCY;
  localparam int DEPTH = L + 2;
  localparam int IDW   = 2;

  logic clk = 1'b0;
  logic rst_n, en, idle, err;
  bit   inj_v;
  int   tests, fails;

  always #5 clk = ~clk;

  sqrt_req_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus ();

`ifdef SQRT_ARB_STATS_EN
  logic [NREQ*32-1:0] stat_issued;
  logic [31:0]        stat_stall;
`endif

  sqrt_req_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .LATENCY(L), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .bus   (bus),
    .idle  (idle),
    .err   (err)
`ifdef SQRT_ARB_STATS_EN
    ,
    .stat_issued (stat_issued),
    .stat_stall  (stat_stall)
`endif
  );

  function automatic logic [WIDTH-1:0] ref_sqrt(input logic [WIDTH-1:0] n);
    longint v, r, t;
    v = longint'(n) << (2 * SQRT_OUT_FRAC);
    r = 0;
    for (int b = WIDTH - 1; b >= 0; b--) begin
      t = r | (longint'(1) << b);
      if (t * t <= v) r = t;
    end
    return r[WIDTH-1:0];
  endfunction

  // Non-stalling pipeline of L stages; inj_v forces a stray result strobe.
  bit               pv [L];
  logic [WIDTH-1:0] pd [L];
  always @(posedge clk) begin
    for (int i = L - 1; i > 0; i--) begin
      pv[i] <= pv[i-1];
      pd[i] <= pd[i-1];
    end
    pv[0] <= bus.sq_in_valid;
    pd[0] <= ref_sqrt(bus.sq_N);
  end
  assign bus.sq_out_valid = pv[L-1] | inj_v;
  assign bus.sq_sqrt      = pd[L-1];

  // Reference model: a result issued in cycle t is ready for the consumer from cycle t+L+2.
  int               cyc, rr_next, outstanding, exp_gid;
  sqrt_rsp_t        exp_q [$];
  int               avail_q [$];
  logic [NREQ-1:0]  exp_ready;
  logic             exp_rsp_v, exp_pop;

  task automatic drive(input logic [NREQ-1:0] v, input logic [NREQ*WIDTH-1:0] d,
                       input logic rr, input logic e);
    int k;
    bus.req_valid = v;
    bus.req_data  = d;
    bus.rsp_ready = rr;
    en            = e;
    #1;
    exp_rsp_v = (exp_q.size() > 0) && (avail_q[0] <= cyc);
    exp_pop   = exp_rsp_v && rr;
    exp_ready = '0;
    exp_gid   = -1;
    if (e && (outstanding - (exp_pop ? 1 : 0)) < DEPTH) begin
      for (int i = 0; i < NREQ; i++) begin
        k = (rr_next + i) % NREQ;
        if (exp_gid < 0 && v[k]) exp_gid = k;
      end
    end
    if (exp_gid >= 0) exp_ready[exp_gid] = 1'b1;
  endtask

  task automatic commit();
    sqrt_rsp_t e;
    if (exp_pop) begin
      void'(exp_q.pop_front());
      void'(avail_q.pop_front());
      outstanding--;
    end
    if (exp_gid >= 0) begin
      e.id   = 3'(exp_gid);
      e.data = ref_sqrt(bus.req_data[exp_gid*WIDTH +: WIDTH]);
      exp_q.push_back(e);
      avail_q.push_back(cyc + L + 2);
      outstanding++;
      rr_next = (exp_gid + 1) % NREQ;
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic apply_reset(input int n);
    rst_n         = 1'b0;
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.rsp_ready = 1'b0;
    en            = 1'b0;
    inj_v         = 1'b0;
    repeat (n) @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    avail_q.delete();
    outstanding = 0;
    rr_next     = 0;
    cyc         = 0;
  endtask

  task automatic test_reset();
    bus.req_valid = '1;
    bus.rsp_ready = 1'b1;
    en            = 1'b1;
    #1;
    tests++;
    if ({bus.req_ready, bus.sq_in_valid, bus.rsp_valid, idle, err} !== {{NREQ{1'b0}}, 1'b0, 1'b0, 1'b1, 1'b0}) begin
      fails++;
      $display("FAIL reset_flags: got %b want %b", {bus.req_ready, bus.sq_in_valid, bus.rsp_valid, idle, err},
               {{NREQ{1'b0}}, 4'b0010});
    end
    tests++;
    if ({bus.sq_N, bus.rsp_id, bus.rsp_data} !== '0) begin
      fails++;
      $display("FAIL reset_data: got %h want 0", {bus.sq_N, bus.rsp_id, bus.rsp_data});
    end
    @(negedge clk);
    apply_reset(20);
  endtask

  task automatic test_single();
    logic [NREQ*WIDTH-1:0] d;
    bit got;
    int diff;
    apply_reset(20);
    d = '0;
    d[WIDTH-1:0] = 16'h0010;
    drive(4'b0001, d, 1'b1, 1'b1);
    tests++;
    if (bus.req_ready !== 4'b0001) begin fails++; $display("FAIL single_grant: got %b want 0001", bus.req_ready); end
    commit();
    got = 1'b0;
    for (int n = 0; n < 60 && !got; n++) begin
      drive('0, '0, 1'b1, 1'b1);
      if (bus.rsp_valid === 1'b1) begin
        got = 1'b1;
        tests++;
        if (cyc != L + 2) begin fails++; $display("FAIL single_latency: got %0d want %0d", cyc, L + 2); end
        tests++;
        if (bus.rsp_id !== 2'd0) begin fails++; $display("FAIL single_id: got %0d want 0", bus.rsp_id); end
        diff = int'(bus.rsp_data) - 'h100;
        tests++;
        if ($isunknown(bus.rsp_data) || diff < -1 || diff > 1) begin
          fails++; $display("FAIL single_data: got %h want 0100", bus.rsp_data);
        end
      end
      commit();
    end
    tests++;
    if (!got) begin fails++; $display("FAIL single_timeout: got no response want one"); end
  endtask

  task automatic test_zero();
    logic [NREQ*WIDTH-1:0] d;
    bit got;
    d = {NREQ{16'hFFFF}};
    d[2*WIDTH +: WIDTH] = '0;
    drive(4'b0100, d, 1'b1, 1'b1);
    tests++;
    if (bus.req_ready !== 4'b0100) begin fails++; $display("FAIL zero_grant: got %b want 0100", bus.req_ready); end
    commit();
    got = 1'b0;
    for (int n = 0; n < 60 && !got; n++) begin
      drive('0, '0, 1'b1, 1'b1);
      if (bus.rsp_valid === 1'b1) begin
        got = 1'b1;
        tests++;
        if ({bus.rsp_id, bus.rsp_data} !== {2'd2, 16'h0000}) begin
          fails++; $display("FAIL zero_rsp: got id %0d data %h want id 2 data 0000", bus.rsp_id, bus.rsp_data);
        end
      end
      commit();
    end
    tests++;
    if (!got) begin fails++; $display("FAIL zero_timeout: got no response want one"); end
    drive('0, '0, 1'b1, 1'b1);
    tests++;
    if (idle !== 1'b1) begin fails++; $display("FAIL zero_idle: got %b want 1", idle); end
    commit();
  endtask

  task automatic test_all_four();
    logic [NREQ-1:0]       v;
    logic [NREQ*WIDTH-1:0] d;
    logic [WIDTH-1:0]      want [NREQ];
    int got, diff;
    want = '{16'h0040, 16'h0080, 16'h00C0, 16'h0280};
    apply_reset(20);
    v = '1;
    d = {16'd100, 16'd9, 16'd4, 16'd1};
    for (int g = 0; g < NREQ; g++) begin
      drive(v, d, 1'b1, 1'b1);
      tests++;
      if (bus.req_ready !== (4'b0001 << g)) begin
        fails++; $display("FAIL four_grant%0d: got %b want %b", g, bus.req_ready, 4'b0001 << g);
      end
      v[g] = 1'b0;
      commit();
    end
    got = 0;
    for (int n = 0; n < 60 && got < NREQ; n++) begin
      drive(v, d, 1'b1, 1'b1);
      if (bus.rsp_valid === 1'b1) begin
        tests++;
        if (bus.rsp_id !== 2'(got) || cyc != L + 2 + got) begin
          fails++; $display("FAIL four_order%0d: got id %0d at %0d want id %0d at %0d", got, bus.rsp_id, cyc, got, L + 2 + got);
        end
        diff = int'(bus.rsp_data) - int'(want[got]);
        tests++;
        if ($isunknown(bus.rsp_data) || diff < -1 || diff > 1) begin
          fails++; $display("FAIL four_data%0d: got %h want %h", got, bus.rsp_data, want[got]);
        end
        got++;
      end
      commit();
    end
    tests++;
    if (got != NREQ) begin fails++; $display("FAIL four_count: got %0d want %0d", got, NREQ); end
  endtask

  task automatic test_backpressure();
    int grants, got;
    sqrt_rsp_t h;
    apply_reset(20);
    grants = 0;
    for (int n = 0; n < 40; n++) begin
      drive('1, {$urandom, $urandom}, 1'b0, 1'b1);
      if (|bus.req_ready) grants++;
      if (n == 39) begin
        tests++;
        if (bus.req_ready !== '0) begin fails++; $display("FAIL bp_ready_low: got %b want 0000", bus.req_ready); end
      end
      commit();
    end
    tests++;
    if (grants != DEPTH) begin fails++; $display("FAIL bp_grants: got %0d want %0d", grants, DEPTH); end
    got = 0;
    for (int n = 0; n < 100 && exp_q.size() > 0; n++) begin
      drive('0, '0, 1'b1, 1'b1);
      tests++;
      if (bus.rsp_valid !== exp_rsp_v) begin fails++; $display("FAIL bp_rsp_valid: got %b want %b", bus.rsp_valid, exp_rsp_v); end
      if (exp_rsp_v) begin
        h = exp_q[0];
        got++;
        tests++;
        if ({bus.rsp_id, bus.rsp_data} !== {h.id[IDW-1:0], h.data}) begin
          fails++; $display("FAIL bp_drain: got id %0d data %h want id %0d data %h", bus.rsp_id, bus.rsp_data, h.id, h.data);
        end
      end
      commit();
    end
    drive('0, '0, 1'b1, 1'b1);
    tests++;
    if (got != DEPTH || bus.rsp_valid !== 1'b0) begin
      fails++; $display("FAIL bp_drain_count: got %0d valid %b want %0d valid 0", got, bus.rsp_valid, DEPTH);
    end
    commit();
  endtask

  task automatic test_reset_mid();
    apply_reset(20);
    for (int n = 0; n < 30; n++) begin
      drive(NREQ'($urandom), {$urandom, $urandom}, 1'($urandom), 1'b1);
      commit();
    end
    rst_n = 1'b0;
    bus.req_valid = '1;
    #1;
    tests++;
    if ({bus.req_ready, bus.sq_in_valid, bus.rsp_valid, idle, err} !== {{NREQ{1'b0}}, 4'b0010} ||
        {bus.sq_N, bus.rsp_id, bus.rsp_data} !== '0) begin
      fails++;
      $display("FAIL midreset_values: got %b %h want %b 0", {bus.req_ready, bus.sq_in_valid, bus.rsp_valid, idle, err},
               {bus.sq_N, bus.rsp_id, bus.rsp_data}, {{NREQ{1'b0}}, 4'b0010});
    end
    @(negedge clk);
    apply_reset(19);
    for (int n = 0; n < 5; n++) begin
      drive('0, '0, 1'b1, 1'b1);
      commit();
    end
    drive('0, '0, 1'b1, 1'b1);
    tests++;
    if ({idle, err, bus.rsp_valid} !== 3'b100) begin
      fails++; $display("FAIL midreset_after: got idle/err/rsp %b want 100", {idle, err, bus.rsp_valid});
    end
    commit();
  endtask

  task automatic test_err();
    apply_reset(20);
    drive('0, '0, 1'b1, 1'b1);
    tests++;
    if (err !== 1'b0) begin fails++; $display("FAIL err_initial: got %b want 0", err); end
    commit();
    inj_v = 1'b1;
    drive('0, '0, 1'b1, 1'b1);
    commit();
    inj_v = 1'b0;
    for (int n = 0; n < 6; n++) begin
      drive('0, '0, 1'b1, 1'b1);
      tests++;
      if ({err, bus.rsp_valid} !== 2'b10) begin
        fails++; $display("FAIL err_sticky%0d: got err/rsp %b want 10", n, {err, bus.rsp_valid});
      end
      commit();
    end
    apply_reset(20);
    drive('0, '0, 1'b1, 1'b1);
    tests++;
    if (err !== 1'b0) begin fails++; $display("FAIL err_cleared: got %b want 0", err); end
    commit();
  endtask

  task automatic test_random();
    sqrt_rsp_t h;
    apply_reset(20);
    for (int n = 0; n < 600; n++) begin
      drive(NREQ'($urandom), {$urandom, $urandom}, ($urandom_range(0, 3) != 0), ($urandom_range(0, 7) != 0));
      tests++;
      if (bus.req_ready !== exp_ready) begin
        fails++; $display("FAIL rand_ready@%0d: got %b want %b", cyc, bus.req_ready, exp_ready);
      end
      tests++;
      if ({bus.rsp_valid, idle} !== {exp_rsp_v, outstanding == 0}) begin
        fails++; $display("FAIL rand_valid_idle@%0d: got %b want %b", cyc, {bus.rsp_valid, idle}, {exp_rsp_v, outstanding == 0});
      end
      if (exp_rsp_v) begin
        h = exp_q[0];
        tests++;
        if ({bus.rsp_id, bus.rsp_data} !== {h.id[IDW-1:0], h.data}) begin
          fails++; $display("FAIL rand_rsp@%0d: got id %0d data %h want id %0d data %h", cyc, bus.rsp_id, bus.rsp_data, h.id, h.data);
        end
      end
      commit();
    end
    for (int n = 0; n < 100 && outstanding > 0; n++) begin
      drive('0, '0, 1'b1, 1'b1);
      commit();
    end
    drive('0, '0, 1'b1, 1'b1);
    tests++;
    if ({idle, err, bus.rsp_valid} !== 3'b100) begin
      fails++; $display("FAIL rand_final: got idle/err/rsp %b want 100", {idle, err, bus.rsp_valid});
    end
    commit();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tests         = 0;
    fails         = 0;
    rst_n         = 1'b0;
    en            = 1'b0;
    inj_v         = 1'b0;
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.rsp_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_single();
    test_zero();
    test_all_four();
    test_backpressure();
    test_reset_mid();
    test_err();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
